seq_detector_mealy: RTL

- Parametrised Mealy sequence detector; successor to the fixed-pattern single-bit Mealy detector.
- Serial bit stream `in` is compared against a PAT_W-bit pattern, which is either the power-up default or loaded at runtime.
- Overlapping or non-overlapping matching is selected by parameter.
- Combinational match pulse `out`, plus a saturating match counter for status readback by the surrounding control logic.

---
 rtl/seq_detector_mealy.sv | 106 ++++++++++
 1 files changed

// File: rtl/seq_detector_mealy.sv
// seq_detector_mealy: parametrised Mealy detector that matches a serial bit stream
// against a runtime-loadable PAT_W-bit pattern (MSB is the first bit received).
// The match pulse is combinational. A saturating counter records the matches for
// status readback.
module seq_detector_mealy #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1101,
    parameter bit               OVERLAP = 1'b1,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in,
    input  logic             load,
    input  logic [PAT_W-1:0] pat_in,
    output logic             out,
    output logic [CNT_W-1:0] match_cnt,
    output logic [PAT_W-1:0] pattern
);

    // fill counts the accepted bits held in history, from 0 to PAT_W-1.
    // Its value is the state index S0..S(PAT_W-1) of the detector.
    localparam int               FILL_W   = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    logic [PAT_W-2:0]  r_hist;
    logic [FILL_W-1:0] r_fill;
    logic [PAT_W-1:0]  r_pat;
    logic [CNT_W-1:0]  r_cnt;

    logic [PAT_W-2:0]  w_hist_nxt;
    logic [FILL_W-1:0] w_fill_nxt;
    logic [PAT_W-1:0]  w_pat_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;

    logic [PAT_W-1:0]  w_window;
    logic              w_accept;
    logic              w_full;
    logic              w_hit;

    // The counter increments and holds once it reaches all ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + 1'b1;
    endfunction

    // The fill level climbs to PAT_W-1 and stays there while the detector is armed.
    function automatic logic [FILL_W-1:0] fill_inc(input logic [FILL_W-1:0] f);
        return (f == FILL_MAX) ? f : f + 1'b1;
    endfunction

    // The candidate window is the stored history with the current bit appended as the newest (LSB).
    assign w_window = {r_hist, in};
    // A load strobe takes priority and the bit on that cycle is discarded.
    assign w_accept = en & ~load;
    assign w_full   = (r_fill == FILL_MAX);
    // The match fires only when a full window of PAT_W bits has been seen.
    // Gating with rst keeps the pulse low while the detector is held in reset.
    assign w_hit    = w_accept & w_full & (w_window == r_pat) & ~rst;

    assign out       = w_hit;
    assign match_cnt = r_cnt;
    assign pattern   = r_pat;

    // Next-state logic: holds by default, then applies load, then an accepted bit.
    always_comb begin
        w_hist_nxt = r_hist;
        w_fill_nxt = r_fill;
        w_pat_nxt  = r_pat;
        w_cnt_nxt  = r_cnt;
        if (load) begin
            w_pat_nxt  = pat_in;
            w_hist_nxt = '0;
            w_fill_nxt = '0;
        end else if (en) begin
            if (w_hit && !OVERLAP) begin
                // In non-overlapping mode the next match needs PAT_W fresh bits.
                w_hist_nxt = '0;
                w_fill_nxt = '0;
            end else begin
                w_hist_nxt = w_window[PAT_W-2:0];
                w_fill_nxt = fill_inc(r_fill);
            end
            if (w_hit) begin
                w_cnt_nxt = sat_inc(r_cnt);
            end
        end
    end

    // State register with asynchronous reset. Reset also restores the power-up pattern.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hist <= '0;
            r_fill <= '0;
            r_pat  <= PATTERN;
            r_cnt  <= '0;
        end else begin
            r_hist <= w_hist_nxt;
            r_fill <= w_fill_nxt;
            r_pat  <= w_pat_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end

endmodule
